dmem_lsu: RTL and testbench

//  Word-organised data memory with a RISC-V load/store front end for the RV32IM core.
//  - Sits between the core's MEM stage and on-chip SRAM.
//  - Takes byte, halfword and word loads/stores through a valid/ready request port.
//  - Returns sign- or zero-extended load data after a configurable latency.
//  - Flags illegal, out-of-range and (optionally) misaligned accesses.

---
 rtl/dmem_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data SRAM behind a RISC-V byte/half/word load/store request port.
// Build option: define DMEM_ALIGN_CHECK_EN to flag misaligned H/HU/W accesses instead of aligning them down.
module dmem_lsu #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNTW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int LAST = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam int PIPE = (LATENCY > 1) ? (LATENCY - 1) : 1;
    localparam logic [31:0] WORDS_U = 32'(WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [15:0] lane;
        lane = 16'(word >> {off, 3'b000});
        case (f3)
            F3_B:    load_fmt = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_fmt = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_fmt = word;
            F3_BU:   load_fmt = {24'h00_0000, lane[7:0]};
            F3_HU:   load_fmt = {16'h0000, lane[15:0]};
            default: load_fmt = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    byte_en = 4'b0001 << off;
            F3_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    logic [31:0]     mem_q [WORDS];

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            accept_s;
    logic            f3_ok_s, align_ok_s, range_ok_s, err_s;
    logic [1:0]      off_s;
    logic [IDXW-1:0] idx_s;
    logic [3:0]      be_s;
    logic [31:0]     wdata_s, rd_word_s, ld_s;
    logic [31:0]     staged_rdata_s;
    logic            staged_err_s;

    assign accept_s  = req_valid & req_ready_q;
    assign idx_s     = req_addr[IDXW+1:2];
    assign rd_word_s = mem_q[idx_s];

    // Request decode: legality, effective lane offset, byte enables and formatted load result.
    always_comb begin
        f3_ok_s    = 1'b0;
        align_ok_s = 1'b1;
        off_s      = req_addr[1:0];
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok_s = 1'b1;
            F3_BU, F3_HU:     f3_ok_s = ~req_we;
            default:          f3_ok_s = 1'b0;
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        case (req_funct3)
            F3_H, F3_HU: align_ok_s = ~req_addr[0];
            F3_W:        align_ok_s = (req_addr[1:0] == 2'b00);
            default:     align_ok_s = 1'b1;
        endcase
`else
        case (req_funct3)
            F3_H, F3_HU: off_s = {req_addr[1], 1'b0};
            F3_W:        off_s = 2'b00;
            default:     off_s = req_addr[1:0];
        endcase
`endif
        // The full upper address is compared so high aliases of a valid index are still rejected.
        range_ok_s = ({2'b00, req_addr[31:2]} < WORDS_U);
        err_s      = ~(f3_ok_s & align_ok_s & range_ok_s);
        if (err_s) begin
            be_s = 4'b0000;
        end else begin
            be_s = byte_en(req_funct3, off_s);
        end
        case (req_funct3)
            F3_B:    wdata_s = {4{req_wdata[7:0]}};
            F3_H:    wdata_s = {2{req_wdata[15:0]}};
            default: wdata_s = req_wdata;
        endcase
        if (err_s | req_we) begin
            ld_s = 32'h0000_0000;
        end else begin
            ld_s = load_fmt(rd_word_s, off_s, req_funct3);
        end
    end

    // SRAM array: byte-lane writes at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s & req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [31:0] pipe_rdata_q [PIPE];
            logic        pipe_err_q   [PIPE];

            // Load-result staging: stage 0 captures at acceptance, later stages shift each cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_rdata_q[i] <= 32'h0000_0000;
                        pipe_err_q[i]   <= 1'b0;
                    end
                end else begin
                    if (accept_s) begin
                        pipe_rdata_q[0] <= ld_s;
                        pipe_err_q[0]   <= err_s;
                    end
                    for (int i = 1; i < PIPE; i++) begin
                        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
                        pipe_err_q[i]   <= pipe_err_q[i-1];
                    end
                end
            end

            assign staged_rdata_s = pipe_rdata_q[PIPE-1];
            assign staged_err_s   = pipe_err_q[PIPE-1];
        end else begin : g_nopipe
            assign staged_rdata_s = 32'h0000_0000;
            assign staged_err_s   = 1'b0;
        end
    endgenerate

    // Next-state and response logic; rdata/err only move when a response is launched.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_s;
                        rsp_err_d   = err_s;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = {CNTW{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNTW'(LAST)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = staged_rdata_s;
                    rsp_err_d   = staged_err_s;
                end else begin
                    cnt_d = cnt_q + CNTW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d != ST_WAIT);
    end

    // Control FSM and registered port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNTW{1'b0}};
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed plus random checks of dmem_lsu against a byte-array reference model.
// Instance dut runs at LATENCY=1, dut3 at LATENCY=3; expectations follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        rst3_n, v3, ready3, we3, rsp_valid3, err3;
    logic [2:0]  f3_3;
    logic [31:0] addr3, wd3, rdata3;

    int          n_tests, n_fail;
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rd, obs_rd;
    logic        last_er, obs_er;

    always #5 clk = ~clk;

    dmem_lsu #(.WORDS(1024), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_lsu #(.WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(ready3),
        .req_we(we3), .req_funct3(f3_3), .req_addr(addr3), .req_wdata(wd3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rdata3), .rsp_err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, rules applied directly.
    function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          size;
        logic [31:0] a, v;
        a    = a_in;
        rd   = 32'h0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        er   = (f3 == 3'd3) || (f3 >= 3'd6) || (f3[2] && we) || (a >= 32'h0000_1000);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((a % 32'(size)) != 32'd0) er = 1'b1;
`else
        a = a - (a % 32'(size));
`endif
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
                if (!f3[2] && size < 4 && v[8*size-1])
                    for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
                rd = v;
            end
        end
    endfunction

    // Called at a negedge; leaves req_valid high so consecutive calls are back-to-back.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_er;
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        ref_access(we, f3, a, wd, exp_rd, exp_er);
        @(posedge clk); @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_er));
        obs_rd = rsp_rdata; obs_er = rsp_err;
        last_rd = exp_rd; last_er = exp_er;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_rdata_hold", rsp_rdata, last_rd);
        check("idle_err_hold", 32'(rsp_err), 32'(last_er));
    endtask

    // LATENCY=3 transaction; the held request is altered during the wait cycles and must be ignored.
    task automatic issue3(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er);
        check("l3_ready_idle", 32'(ready3), 32'd1);
        v3 = 1'b1; we3 = we; f3_3 = f3; addr3 = a; wd3 = wd;
        @(posedge clk); @(negedge clk);
        check("l3_ready_w1", 32'(ready3), 32'd0);
        check("l3_valid_w1", 32'(rsp_valid3), 32'd0);
        we3 = 1'b1; f3_3 = 3'b010; wd3 = ~wd;
        @(posedge clk); @(negedge clk);
        check("l3_ready_w2", 32'(ready3), 32'd0);
        check("l3_valid_w2", 32'(rsp_valid3), 32'd0);
        @(posedge clk); @(negedge clk);
        check("l3_rsp_valid", 32'(rsp_valid3), 32'd1);
        check("l3_rsp_rdata", rdata3, exp_rd);
        check("l3_rsp_err", 32'(err3), 32'(exp_er));
        check("l3_ready_resp", 32'(ready3), 32'd1);
        v3 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("l3_valid_fall", 32'(rsp_valid3), 32'd0);
        check("l3_rdata_hold", rdata3, exp_rd);
    endtask

    // Accept a request, then reset one cycle later: no response may appear.
    task automatic reset_mid(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        check("rm_ready", 32'(ready3), 32'd1);
        v3 = 1'b1; we3 = we; f3_3 = f3; addr3 = a; wd3 = wd;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(posedge clk);
        #1 rst3_n = 1'b0;
        #1 check("rm_ready_async", 32'(ready3), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rm_rst_ready", 32'(ready3), 32'd0);
            check("rm_rst_valid", 32'(rsp_valid3), 32'd0);
            check("rm_rst_rdata", rdata3, 32'h0);
        end
        rst3_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rm_ready_after", 32'(ready3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rm_no_pulse", 32'(rsp_valid3), 32'd0);
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        last_rd = 32'h0; last_er = 1'b0;
        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        v3 = 1'b0; we3 = 1'b0; f3_3 = 3'b010; addr3 = 32'h0; wd3 = 32'h0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_rdata", rsp_rdata, 32'h0);
            check("rst_err", 32'(rsp_err), 32'd0);
        end
        rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_ready3", 32'(ready3), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);

        for (int w = 0; w < 128; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);
        idle();

        issue(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h104, 32'h0);
        check("t1_lw", obs_rd, 32'hDEAD_BEEF);
        issue(1'b0, 3'b000, 32'h107, 32'h0);
        check("t2_lb", obs_rd, 32'hFFFF_FFDE);
        issue(1'b0, 3'b100, 32'h107, 32'h0);
        check("t2_lbu", obs_rd, 32'h0000_00DE);
        issue(1'b0, 3'b001, 32'h106, 32'h0);
        check("t2_lh", obs_rd, 32'hFFFF_DEAD);
        issue(1'b0, 3'b101, 32'h104, 32'h0);
        check("t2_lhu", obs_rd, 32'h0000_BEEF);
        issue(1'b1, 3'b000, 32'h105, 32'h1234_56AA);
        issue(1'b0, 3'b010, 32'h104, 32'h0);
        check("t3_sb", obs_rd, 32'hDEAD_AAEF);
        issue(1'b1, 3'b001, 32'h106, 32'h0000_1234);
        issue(1'b0, 3'b010, 32'h104, 32'h0);
        check("t3_sh", obs_rd, 32'h1234_AAEF);
        idle();

        issue(1'b1, 3'b010, 32'h100, 32'h0BAD_F00D);
        issue(1'b0, 3'b010, 32'h1000, 32'h0);
        check("t4_oor_err", 32'(obs_er), 32'd1);
        check("t4_oor_rdata", obs_rd, 32'h0);
        issue(1'b0, 3'b011, 32'h104, 32'h0);
        check("t4_f3_err", 32'(obs_er), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        check("t4_mis_lw_err", 32'(obs_er), 32'd1);
        issue(1'b1, 3'b001, 32'h103, 32'h0000_FFFF);
        check("t4_mis_sh_err", 32'(obs_er), 32'd1);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        check("t4_mis_sh_nowrite", obs_rd, 32'h0BAD_F00D);
`else
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        check("t4_alignw_rdata", obs_rd, 32'h0BAD_F00D);
        check("t4_alignw_err", 32'(obs_er), 32'd0);
`endif
        idle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) idle();
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
            else a = 32'($urandom_range(0, 511));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        idle();

        issue3(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'h0, 1'b0);
        issue3(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 1'b0);
        issue3(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 1'b0);
        issue3(1'b0, 3'b101, 32'h1000, 32'h0, 32'h0, 1'b1);
        issue3(1'b0, 3'b000, 32'h203, 32'h0, 32'hFFFF_FFCA, 1'b0);
        reset_mid(1'b0, 3'b010, 32'h200, 32'h0);
        reset_mid(1'b1, 3'b010, 32'h204, 32'h1122_3344);
        issue3(1'b0, 3'b010, 32'h204, 32'h0, 32'h1122_3344, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
